// File: rtl/fft_ctrl.sv
// Address sequencer for an in-place radix-2 DIT FFT: issues one butterfly's
// A/B/twiddle read addresses per cycle, with a drain gap between stages.
module fft_ctrl #(
    parameter int ADDR_SIZE    = 5,
    parameter int PIPE_LATENCY = 4
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic [ADDR_SIZE-1:0] o_rdaddr_A,
    output logic [ADDR_SIZE-1:0] o_rdaddr_B,
    output logic [ADDR_SIZE-2:0] o_rdaddr_twiddle,
    output logic                 o_rd_en,
    output logic                 o_wr_en,
    output logic [ADDR_SIZE-1:0] o_stage,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int JW = ADDR_SIZE - 1;
    localparam int DW = $clog2(PIPE_LATENCY + 1);
    localparam logic [JW-1:0]        J_LAST     = {JW{1'b1}};
    localparam logic [ADDR_SIZE-1:0] S_LAST     = ADDR_SIZE'(ADDR_SIZE - 1);
    localparam logic [DW-1:0]        DRAIN_LOAD = DW'(PIPE_LATENCY);
    localparam logic [DW-1:0]        DRAIN_ONE  = DW'(1);

    // ST_ARM is the extra cycle between accepting i_start and the first read
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  r_state_r, w_state_nxt_s;
    logic [ADDR_SIZE-1:0]    r_s_r, w_s_nxt_s;
    logic [JW-1:0]           r_j_r, w_j_nxt_s;
    logic [DW-1:0]           r_drain_r, w_drain_nxt_s;
    logic                    w_clear_s;
    logic [PIPE_LATENCY-1:0] r_wr_sr_r;

    logic [ADDR_SIZE-1:0]    w_span_s, w_jx_s, w_grp_s, w_pos_s, w_a_s, w_b_s;
    logic [JW-1:0]           w_tw_s;

    // Next-state and counter update for the stage/butterfly walk
    always_comb begin
        w_state_nxt_s = r_state_r;
        w_s_nxt_s     = r_s_r;
        w_j_nxt_s     = r_j_r;
        w_drain_nxt_s = r_drain_r;
        w_clear_s     = 1'b0;
        if (i_abort) begin
            w_state_nxt_s = ST_IDLE;
            w_s_nxt_s     = '0;
            w_j_nxt_s     = '0;
            w_drain_nxt_s = '0;
            w_clear_s     = 1'b1;
        end else begin
            case (r_state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        w_state_nxt_s = ST_ARM;
                    end else begin
                        w_state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    w_state_nxt_s = ST_RUN;
                    w_s_nxt_s     = '0;
                    w_j_nxt_s     = '0;
                end
                ST_RUN: begin
                    if (r_j_r == J_LAST) begin
                        w_state_nxt_s = ST_DRAIN;
                        w_drain_nxt_s = DRAIN_LOAD;
                        w_j_nxt_s     = '0;
                    end else begin
                        w_j_nxt_s = r_j_r + JW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_r == DRAIN_ONE) begin
                        w_drain_nxt_s = '0;
                        if (r_s_r == S_LAST) begin
                            w_state_nxt_s = ST_DONE;
                        end else begin
                            w_state_nxt_s = ST_RUN;
                            w_s_nxt_s     = r_s_r + ADDR_SIZE'(1);
                        end
                    end else begin
                        w_drain_nxt_s = r_drain_r - DRAIN_ONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt_s = ST_IDLE;
                end
                default: begin
                    w_state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Butterfly addresses for the upcoming (s, j): A has a 0 inserted at bit s
    always_comb begin
        w_span_s = ADDR_SIZE'(1) << w_s_nxt_s;
        w_jx_s   = {1'b0, w_j_nxt_s};
        w_grp_s  = w_jx_s >> w_s_nxt_s;
        w_pos_s  = w_jx_s & (w_span_s - ADDR_SIZE'(1));
        w_a_s    = (w_grp_s << (w_s_nxt_s + ADDR_SIZE'(1))) | w_pos_s;
        w_b_s    = w_a_s + w_span_s;
        w_tw_s   = w_pos_s[JW-1:0] << (S_LAST - w_s_nxt_s);
    end

    // State, counters and all registered outputs
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state_r        <= ST_IDLE;
            r_s_r            <= '0;
            r_j_r            <= '0;
            r_drain_r        <= '0;
            r_wr_sr_r        <= '0;
            o_rdaddr_A       <= '0;
            o_rdaddr_B       <= '0;
            o_rdaddr_twiddle <= '0;
            o_rd_en          <= 1'b0;
            o_stage          <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            r_state_r <= w_state_nxt_s;
            r_s_r     <= w_s_nxt_s;
            r_j_r     <= w_j_nxt_s;
            r_drain_r <= w_drain_nxt_s;
            o_rd_en   <= (w_state_nxt_s == ST_RUN);
            o_busy    <= (w_state_nxt_s == ST_RUN) || (w_state_nxt_s == ST_DRAIN);
            o_done    <= (w_state_nxt_s == ST_DONE);
            o_stage   <= w_s_nxt_s;
            if (w_state_nxt_s == ST_RUN) begin
                o_rdaddr_A       <= w_a_s;
                o_rdaddr_B       <= w_b_s;
                o_rdaddr_twiddle <= w_tw_s;
            end
            if (w_clear_s) begin
                r_wr_sr_r <= '0;
            end else begin
                r_wr_sr_r <= (r_wr_sr_r << 1'b1) | PIPE_LATENCY'(o_rd_en);
            end
        end
    end

    assign o_wr_en = r_wr_sr_r[PIPE_LATENCY-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed self-checking bench for fft_ctrl at default parameters (N=32, latency 4).
module tb_fft_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [4:0] rd_a, rd_b, stage;
    logic [3:0] rd_tw;
    logic       rd_en, wr_en, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    fft_ctrl #(.ADDR_SIZE(5), .PIPE_LATENCY(4)) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_start(start), .i_abort(abort),
        .o_rdaddr_A(rd_a), .o_rdaddr_B(rd_b), .o_rdaddr_twiddle(rd_tw),
        .o_rd_en(rd_en), .o_wr_en(wr_en), .o_stage(stage),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        n_cmp++; if (rd_a  !== 5'd0) begin n_err++; $display("FAIL %s rdaddr_A got %0d want 0", tag, rd_a); end
        n_cmp++; if (rd_b  !== 5'd0) begin n_err++; $display("FAIL %s rdaddr_B got %0d want 0", tag, rd_b); end
        n_cmp++; if (rd_tw !== 4'd0) begin n_err++; $display("FAIL %s twiddle got %0d want 0", tag, rd_tw); end
        n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL %s rd_en got %b want 0", tag, rd_en); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL %s wr_en got %b want 0", tag, wr_en); end
        n_cmp++; if (stage !== 5'd0) begin n_err++; $display("FAIL %s stage got %0d want 0", tag, stage); end
        n_cmp++; if (busy  !== 1'b0) begin n_err++; $display("FAIL %s busy got %b want 0", tag, busy); end
        n_cmp++; if (done  !== 1'b0) begin n_err++; $display("FAIL %s done got %b want 0", tag, done); end
    endtask

    // After return we are at the negedge following the edge that sampled i_start (c=0)
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy got %b want 0", busy); end
    endtask

    // Full FFT walk; i_start is re-pulsed at cycles ign1/ign2 and must be ignored
    task automatic run_full(input string tag, input int ign1, input int ign2);
        logic [4:0] ah [121];
        logic [4:0] bh [121];
        int seen [32];
        int wcyc [32];
        int wstg [32];
        int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
        int s, jj, span, ea, eb, etw;
        logic erd, ewr, ebusy, edone;
        logic [4:0] wa, wb;
        for (int i = 0; i < 32; i++) begin seen[i] = 0; wcyc[i] = -1; wstg[i] = -1; end
        pulse_start();
        for (int c = 0; c <= 110; c++) begin
            s     = (c - 1) / 20;
            jj    = (c - 1) % 20;
            erd   = (c >= 1) && (c <= 100) && (jj < 16);
            ewr   = (c >= 5) && (c <= 104) && (((c - 5) % 20) < 16);
            ebusy = (c >= 1) && (c <= 100);
            edone = (c == 101);
            n_cmp++; if (rd_en !== erd)   begin n_err++; $display("FAIL %s rd_en c=%0d got %b want %b", tag, c, rd_en, erd); end
            n_cmp++; if (wr_en !== ewr)   begin n_err++; $display("FAIL %s wr_en c=%0d got %b want %b", tag, c, wr_en, ewr); end
            n_cmp++; if (busy  !== ebusy) begin n_err++; $display("FAIL %s busy c=%0d got %b want %b", tag, c, busy, ebusy); end
            n_cmp++; if (done  !== edone) begin n_err++; $display("FAIL %s done c=%0d got %b want %b", tag, c, done, edone); end
            ah[c] = rd_a;
            bh[c] = rd_b;
            if (erd) begin
                span = 1 << s;
                ea   = jj + (jj & ~(span - 1));
                eb   = ea + span;
                etw  = (jj % span) << (4 - s);
                n_cmp++; if (rd_a  !== 5'(ea))  begin n_err++; $display("FAIL %s A s=%0d j=%0d got %0d want %0d", tag, s, jj, rd_a, ea); end
                n_cmp++; if (rd_b  !== 5'(eb))  begin n_err++; $display("FAIL %s B s=%0d j=%0d got %0d want %0d", tag, s, jj, rd_b, eb); end
                n_cmp++; if (rd_tw !== 4'(etw)) begin n_err++; $display("FAIL %s tw s=%0d j=%0d got %0d want %0d", tag, s, jj, rd_tw, etw); end
                n_cmp++; if (stage !== 5'(s))   begin n_err++; $display("FAIL %s stage c=%0d got %0d want %0d", tag, c, stage, s); end
                if (c == 4) begin
                    n_cmp++; if ({rd_a, rd_b, rd_tw} !== {5'd6, 5'd7, 4'd0})
                        begin n_err++; $display("FAIL %s spot s0j3 got %0d/%0d/%0d want 6/7/0", tag, rd_a, rd_b, rd_tw); end
                end
                if (c == 46) begin
                    n_cmp++; if ({rd_a, rd_b, rd_tw} !== {5'd9, 5'd13, 4'd4})
                        begin n_err++; $display("FAIL %s spot s2j5 got %0d/%0d/%0d want 9/13/4", tag, rd_a, rd_b, rd_tw); end
                end
                if (c == 96) begin
                    n_cmp++; if ({rd_a, rd_b, rd_tw} !== {5'd15, 5'd31, 4'd15})
                        begin n_err++; $display("FAIL %s spot s4j15 got %0d/%0d/%0d want 15/31/15", tag, rd_a, rd_b, rd_tw); end
                end
                if (s > 0) begin
                    n_cmp++;
                    if (!(wstg[rd_a] == s - 1 && wcyc[rd_a] < c && wstg[rd_b] == s - 1 && wcyc[rd_b] < c)) begin
                        n_err++;
                        $display("FAIL %s raw_order c=%0d A=%0d wstg=%0d B=%0d wstg=%0d want prior stage %0d", tag, c, rd_a, wstg[rd_a], rd_b, wstg[rd_b], s - 1);
                    end
                end
                seen[rd_a]++;
                seen[rd_b]++;
                if (jj == 15) begin
                    int bad = 0;
                    for (int i = 0; i < 32; i++) begin
                        if (seen[i] != 1) bad++;
                        seen[i] = 0;
                    end
                    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL %s coverage stage=%0d got %0d bad addresses want 0", tag, s, bad); end
                end
            end
            if (wr_en === 1'b1 && c >= 4) begin
                wa = ah[c - 4];
                wb = bh[c - 4];
                wcyc[wa] = c; wstg[wa] = (c - 5) / 20;
                wcyc[wb] = c; wstg[wb] = (c - 5) / 20;
            end
            if (rd_en === 1'b1) rd_cnt++;
            if (wr_en === 1'b1) wr_cnt++;
            if (done  === 1'b1) done_cnt++;
            start = (c == ign1) || (c == ign2);
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (rd_cnt   != 80) begin n_err++; $display("FAIL %s rd_count got %0d want 80", tag, rd_cnt); end
        n_cmp++; if (wr_cnt   != 80) begin n_err++; $display("FAIL %s wr_count got %0d want 80", tag, wr_cnt); end
        n_cmp++; if (done_cnt != 1)  begin n_err++; $display("FAIL %s done_count got %0d want 1", tag, done_cnt); end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (busy !== 1'b0 || rd_en !== 1'b0)
                begin n_err++; $display("FAIL start_abort_idle c=%0d busy=%b rd_en=%b want 0/0", c, busy, rd_en); end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        pulse_start();
        repeat (63) @(negedge clk);
        n_cmp++; if (rd_en !== 1'b1 || stage !== 5'd3 || rd_a !== 5'd2)
            begin n_err++; $display("FAIL abort_pre rd_en=%b stage=%0d A=%0d want 1/3/2", rd_en, stage, rd_a); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy  !== 1'b0) begin n_err++; $display("FAIL abort busy got %b want 0", busy); end
        n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL abort rd_en got %b want 0", rd_en); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL abort wr_en got %b want 0", wr_en); end
        for (int c = 0; c < 110; c++) begin
            if (done === 1'b1 || busy === 1'b1 || wr_en === 1'b1) done_cnt++;
            @(negedge clk);
        end
        n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", done_cnt); end
        run_full("after_abort", -1, -1);
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        repeat (48) @(negedge clk);
        n_cmp++; if (rd_en !== 1'b1 || stage !== 5'd2 || rd_a !== 5'd11 || rd_b !== 5'd15)
            begin n_err++; $display("FAIL rst_mid_pre rd_en=%b stage=%0d A=%0d B=%0d want 1/2/11/15", rd_en, stage, rd_a, rd_b); end
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || rd_en !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_idle busy=%b rd_en=%b want 0/0", busy, rd_en); end
        run_full("after_reset", -1, -1);
    endtask

    initial begin
        test_reset();
        run_full("basic", -1, -1);
        run_full("start_ignored", 5, 18);
        test_start_abort_idle();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
